// File: rtl/iiitb_sd_serializer.sv
// iiitb_sd_serializer
// Parallel-to-serial front end for the sequence detector. Takes one
// WIDTH-bit word at a time over a valid/ready handshake, buffers one word
// in a holding register, and shifts the active word out one bit per enabled
// cycle on sequence_out. Words arriving back to back leave the shifter with
// no idle bit between them.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready.
// in_ready is the registered "holding register empty" flag only. It has no
// combinational path from in_valid or shift_en.
//
// Build option: define SD_LSB_FIRST_EN to serialize LSB first. The default
// build serializes MSB first. Handshake and timing are the same in both.
//
// o_dbg_state shows the current FSM state (0 = IDLE, 1 = SHIFT).
module iiitb_sd_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy,
    output logic             o_dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_word_done;

    logic             w_shifting;
    logic             w_last;
    logic             w_accept;
    logic             w_transfer;

    // Event decode: a consumed bit, the final bit of a word, an accept, a transfer
    always_comb begin
        w_shifting = (r_state == S_SHIFT) && shift_en;
        w_last     = w_shifting && (r_bit_cnt == LAST_CNT);
        w_accept   = in_valid && !r_hold_full;
        w_transfer = r_hold_full && ((r_state == S_IDLE) || w_last);
    end

    // Next state: a transfer always starts a word; finishing with nothing buffered idles
    always_comb begin
        w_state_nxt = r_state;
        if (w_transfer) begin
            w_state_nxt = S_SHIFT;
        end else if (w_last) begin
            w_state_nxt = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding register: accept and transfer never both apply on one edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_transfer) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Shift register and bit counter: load on transfer, advance on each non-final enabled bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_transfer) begin
                r_shreg   <= r_hold;
                r_bit_cnt <= '0;
            end else if (w_shifting && !w_last) begin
`ifdef SD_LSB_FIRST_EN
                r_shreg   <= {1'b0, r_shreg[WIDTH-1:1]};
`else
                r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
`endif
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Word-done pulse for the cycle after the last bit is consumed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= w_last;
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        in_ready    = !r_hold_full;
        bit_valid   = (r_state == S_SHIFT);
        busy        = (r_state == S_SHIFT) || r_hold_full;
        word_done   = r_word_done;
        o_dbg_state = r_state;
        sequence_out = 1'b0;
        if (r_state == S_SHIFT) begin
`ifdef SD_LSB_FIRST_EN
            sequence_out = r_shreg[0];
`else
            sequence_out = r_shreg[WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_iiitb_sd_serializer.sv
// Directed testbench for iiitb_sd_serializer (WIDTH = 8).
// Inputs change 1 ns after the rising edge and outputs are sampled there,
// well away from the active edge.
module tb_iiitb_sd_serializer;

    localparam int WIDTH = 8;

`ifdef SD_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             sequence_out;
    logic             bit_valid;
    logic             word_done;
    logic             busy;
    logic             o_dbg_state;

    int checks;
    int errors;

    iiitb_sd_serializer #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_en     (shift_en),
        .sequence_out (sequence_out),
        .bit_valid    (bit_valid),
        .word_done    (word_done),
        .busy         (busy),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // serial order of bit k of word w for this build
    function automatic logic ser_bit(input logic [WIDTH-1:0] w, input int k);
        logic [WIDTH-1:0] t;
        t = w;
        return LSB_FIRST ? t[k] : t[WIDTH-1-k];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_seq_out"}, 32'(sequence_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    logic [WIDTH-1:0] single_word;
    logic [WIDTH-1:0] single_pat;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        shift_en = 1'b0;

        // ---- reset values ----
        #2;
        chk_idle("rst");
        chk("rst_word_done", 32'(word_done), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_idle("post_rst");

        // ---- single word: serial pattern 1,0,1,1,1,0,0,0 ----
        single_word = LSB_FIRST ? 8'h1D : 8'hB8;
        single_pat  = 8'b1011_1000;            // first bit on the left
        in_data  = single_word;
        in_valid = 1'b1;
        shift_en = 1'b1;
        tick();                                // E0: accept
        chk("single_accept_ready", 32'(in_ready), 32'd0);
        chk("single_accept_busy", 32'(busy), 32'd1);
        chk("single_accept_bv", 32'(bit_valid), 32'd0);
        in_valid = 1'b0;
        tick();                                // E1: transfer
        chk("single_xfer_ready", 32'(in_ready), 32'd1);
        chk("single_xfer_state", 32'(o_dbg_state), 32'd1);
        for (int k = 0; k < WIDTH; k++) begin
            chk($sformatf("single_bv%0d", k), 32'(bit_valid), 32'd1);
            chk($sformatf("single_bit%0d", k), 32'(sequence_out), 32'(single_pat[WIDTH-1-k]));
            chk($sformatf("single_wd%0d", k), 32'(word_done), 32'd0);
            tick();
        end
        chk("single_done_pulse", 32'(word_done), 32'd1);
        chk("single_done_bv", 32'(bit_valid), 32'd0);
        chk("single_done_seq", 32'(sequence_out), 32'd0);
        tick();
        chk("single_done_clear", 32'(word_done), 32'd0);
        chk_idle("single_end");

        // ---- back-to-back: B8 then FF, 16 bits with no gap ----
        in_data  = 8'hB8;
        in_valid = 1'b1;
        tick();                                // E0: accept B8
        chk("b2b_ready_full", 32'(in_ready), 32'd0);
        in_data = 8'hFF;
        tick();                                // E1: transfer B8
        chk("b2b_ready_after_xfer", 32'(in_ready), 32'd1);
        for (int k = 0; k < 2 * WIDTH; k++) begin
            chk($sformatf("b2b_bv%0d", k), 32'(bit_valid), 32'd1);
            chk($sformatf("b2b_bit%0d", k), 32'(sequence_out),
                32'(k < WIDTH ? ser_bit(8'hB8, k) : ser_bit(8'hFF, k - WIDTH)));
            if (k == 1) begin
                chk("b2b_ready_hold_full", 32'(in_ready), 32'd0);
                in_valid = 1'b0;
            end
            if (k == WIDTH) begin
                chk("b2b_mid_word_done", 32'(word_done), 32'd1);
                chk("b2b_ready_after_2nd_xfer", 32'(in_ready), 32'd1);
            end
            tick();
        end
        chk("b2b_done_pulse", 32'(word_done), 32'd1);
        chk("b2b_done_bv", 32'(bit_valid), 32'd0);
        tick();
        chk_idle("b2b_end");

        // ---- shift_en toggled: A5, each bit held two cycles ----
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();                                // accept
        in_valid = 1'b0;
        tick();                                // transfer
        for (int k = 0; k < WIDTH; k++) begin
            chk($sformatf("tog_bit%0d_a", k), 32'(sequence_out), 32'(ser_bit(8'hA5, k)));
            shift_en = 1'b0;
            tick();
            chk($sformatf("tog_bit%0d_b", k), 32'(sequence_out), 32'(ser_bit(8'hA5, k)));
            chk($sformatf("tog_bv%0d", k), 32'(bit_valid), 32'd1);
            chk($sformatf("tog_wd%0d", k), 32'(word_done), 32'd0);
            shift_en = 1'b1;
            tick();
        end
        chk("tog_done_pulse", 32'(word_done), 32'd1);
        tick();
        chk_idle("tog_end");

        // ---- reset after 3 bits of B8, with a second word buffered ----
        in_data  = 8'hB8;
        in_valid = 1'b1;
        tick();                                // accept B8
        in_data = 8'hFF;
        tick();                                // transfer B8
        tick();                                // accept FF, bit 1 shown
        in_valid = 1'b0;
        tick();                                // bit 2 shown
        tick();                                // bit 3 shown: 3 bits consumed
        chk("mid_bit3", 32'(sequence_out), 32'(ser_bit(8'hB8, 3)));
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_state", 32'(o_dbg_state), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk_idle("mid_release");

        // ---- new word 01 serializes cleanly ----
        in_data  = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < WIDTH; k++) begin
            chk($sformatf("w01_bv%0d", k), 32'(bit_valid), 32'd1);
            chk($sformatf("w01_bit%0d", k), 32'(sequence_out), 32'(ser_bit(8'h01, k)));
            tick();
        end
        chk("w01_done_pulse", 32'(word_done), 32'd1);
        tick();
        chk_idle("w01_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
